ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage for the single-issue RISC-V core. It owns the program counter, drives the word address into the combinational instruction memory (`imem`), captures the returned word into a registered IF/ID output, and hands it to decode over a valid/ready handshake. It also absorbs control-flow redirects from execute and counts retired fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0013: value held on `instr_o` while reset or flushed (`addi x0,x0,0`).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_a` out 32: fetch byte address to `imem`; combinational copy of `pc_q`.
- `imem_rd` in 32: instruction word from `imem`, valid in the same cycle as `imem_a`.
- `en_i` in 1: fetch enable; when low, no new fetch is launched.
- `redirect_i` in 1: one-cycle request to change the fetch PC (branch, jump or trap).
- `redirect_pc_i` in 32: target address for `redirect_i`.
- `valid_o` out 1: `instr_o`/`pc_o` hold a live instruction.
- `ready_i` in 1: decode accepts the output this cycle.
- `instr_o` out 32: fetched instruction.
- `pc_o` out 32: address of `instr_o`.
- `pc_plus4_o` out 32: `pc_o + 4`, modulo 2^32.
- `misalign_o` out 1: one-cycle pulse, redirect target had bits [1:0] != 0.
- `fetch_cnt_o` out 32: number of handshakes (`valid_o && ready_i`) since reset; wraps.

## Operation
- State: `pc_q`, output register {`valid_q`, `instr_q`, `pcout_q`}, `misalign_q`, `cnt_q`.
- Reset values: `pc_q`=RESET_PC, `valid_o`=0, `instr_o`=NOP_INSTR, `pc_o`=0, `pc_plus4_o`=4, `misalign_o`=0, `fetch_cnt_o`=0. `imem_a`=RESET_PC during reset.
- `advance` = `en_i && (!valid_q || ready_i) && !redirect_i`.
- Priority per edge, highest first:
  - redirect: `pc_q` <= {`redirect_pc_i`[31:2],2'b00}; `valid_q` <= 0; `instr_q` <= NOP_INSTR; `misalign_q` <= |`redirect_pc_i`[1:0]. This applies regardless of `ready_i` or `en_i`. The held instruction is discarded, but it is still counted if `valid_o && ready_i` on that edge.
  - advance: `instr_q` <= `imem_rd`; `pcout_q` <= `pc_q`; `valid_q` <= 1; `pc_q` <= `pc_q` + 4.
  - drain: if `valid_q && ready_i` and `en_i`=0, then `valid_q` <= 0; `pc_q` holds.
  - stall: if `valid_q && !ready_i`, all output register fields and `pc_q` hold; outputs stay stable.
- `misalign_q` clears on the next edge without a misaligned redirect.
- `cnt_q` increments on every edge where `valid_o && ready_i`; wraps from 0xFFFF_FFFF to 0.
- PC arithmetic is 32-bit unsigned modulo 2^32. 0xFFFF_FFFC + 4 = 0x0000_0000.
- `pc_plus4_o` is combinational from `pcout_q`.

## Timing
- `imem_a` changes only after a clock edge or an async reset; `imem_rd` is sampled at the same edge.
- Fetch latency is 1 cycle: instruction at `pc_q` appears on `instr_o` after the edge that launches it.
- With `ready_i` held at 1 and no redirects, throughput is one instruction per cycle, with no bubbles.
- First `valid_o` comes 1 edge after `rst_n` deasserts, provided `en_i`=1.
- Redirect taken at edge N:
  - `valid_o`=0 during cycle N+1.
  - Target instruction is valid after edge N+1.
  - Redirect penalty is one bubble.
- Back-to-back redirects: each one overrides. `valid_o` stays 0 until the first edge without `redirect_i`.
- `rst_n` asserted mid-operation clears everything immediately (async), including a pending stalled instruction; no state survives.

## Test plan
- **Reset and stream:** imem holds `mem[i]`=32'hA000_0000+i. Release reset with `en_i`=1, `ready_i`=1 → consecutive cycles show (`pc_o`,`instr_o`) = (0x0,A0000000), (0x4,A0000001), (0x8,A0000002). `fetch_cnt_o` reaches 3 after the third accepted cycle.
- **Stall:** drop `ready_i` for 3 cycles while `pc_o`=0x8 → `instr_o`=A0000002 and `imem_a`=0xC stay constant, `fetch_cnt_o` frozen. Raise `ready_i` → next output is (0xC,A0000003).
- **Redirect:** assert `redirect_i` with target 0x40 while the output is valid and stalled → next cycle `valid_o`=0 and `instr_o`=0x00000013. The following cycle shows (0x40,A0000010).
- **Misaligned redirect:** target 0x46 → `misalign_o`=1 for exactly one cycle, then the fetch resumes at `pc_o`=0x44.
- **Wrap:** redirect to 0xFFFF_FFFC → `pc_o`=0xFFFF_FFFC with `pc_plus4_o`=0x0, and the next `pc_o`=0x0.
- **Enable and async reset:** deassert `en_i` with `ready_i`=1 → `valid_o` falls after one edge and `imem_a` holds. Assert `rst_n`=0 between edges → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage. Owns the PC, addresses the
//               combinational imem, registers the returned word into the
//               IF/ID output and hands it to decode over valid/ready.
//               Absorbs redirects from execute and counts handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pcout;
    logic        r_misalign;
    logic [31:0] r_cnt;

    logic        w_advance;
    logic        w_handshake;
    logic        w_drain;

    // A new fetch launches when enabled, the output slot is free or being
    // consumed, and no redirect is overriding this edge.
    always_comb begin
        w_handshake = r_valid && ready_i;
        w_advance   = en_i && (!r_valid || ready_i) && !redirect_i;
        w_drain     = w_handshake && !en_i;
    end

    // PC and IF/ID output register: redirect beats advance beats drain;
    // anything else (stall or idle) holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pcout <= 32'd0;
        end else if (redirect_i) begin
            r_pc    <= {redirect_pc_i[31:2], 2'b00};
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (w_advance) begin
            r_instr <= imem_rd;
            r_pcout <= r_pc;
            r_valid <= 1'b1;
            r_pc    <= r_pc + c_pc_step;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    // Misalignment flag is a single-cycle pulse tied to the redirect edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
        end
    end

    // Handshake counter; a handshake on a redirect edge still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 32'd0;
        end else if (w_handshake) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Output drive; pc_plus4 wraps naturally in 32 bits.
    always_comb begin
        imem_a      = r_pc;
        valid_o     = r_valid;
        instr_o     = r_instr;
        pc_o        = r_pcout;
        pc_plus4_o  = r_pcout + c_pc_step;
        misalign_o  = r_misalign;
        fetch_cnt_o = r_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit. The driver issues
//               per-cycle stimulus records into a queue; a monitor pops one
//               per cycle and checks the DUT against a stream-level model
//               (next instruction address decode should see, occupancy,
//               handshake count, misalign pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    typedef struct {
        logic        en;
        logic        ready;
        logic        redir;
        logic [31:0] tgt;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    int checks   = 0;
    int failures = 0;

    stim_t stim_q[$];
    bit    mon_on = 1'b0;

    // Reference model state
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic        m_nop;

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_a       (imem_a),
        .imem_rd      (imem_rd),
        .en_i         (en_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .misalign_o   (misalign_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    // Instruction memory: word i holds A0000000 + i
    assign imem_rd = mem_word(imem_a);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic rdy, input logic redir, input logic [31:0] tgt);
        stim_t s;
        en_i          = en;
        ready_i       = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        s.en = en; s.ready = rdy; s.redir = redir; s.tgt = tgt;
        stim_q.push_back(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: check the current cycle against the model, then fold this
    // cycle's stimulus into the model for the next edge.
    always @(negedge clk) begin
        if (mon_on) begin
            stim_t s;
            logic  hs;
            if (stim_q.size() == 0) begin
                failures++;
                $display("FAIL stim_underrun actual=0 expected=1 at %0t", $time);
            end else begin
                s = stim_q.pop_front();
                chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
                chk("fetch_cnt", fetch_cnt_o, m_cnt);
                chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
                chk("imem_a", imem_a, m_valid ? m_pc + 32'd4 : m_pc);
                if (m_valid) begin
                    chk("pc_o", pc_o, m_pc);
                    chk("instr_o", instr_o, mem_word(m_pc));
                    chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
                end else if (m_nop) begin
                    chk("instr_nop", instr_o, c_nop);
                end
                hs = m_valid && s.ready;
                if (hs) m_cnt = m_cnt + 32'd1;
                if (s.redir) begin
                    m_pc    = {s.tgt[31:2], 2'b00};
                    m_valid = 1'b0;
                    m_nop   = 1'b1;
                    m_mis   = (s.tgt[1:0] != 2'b00);
                end else begin
                    m_mis = 1'b0;
                    if (hs) m_pc = m_pc + 32'd4;
                    if (s.en && (!m_valid || s.ready)) begin
                        m_valid = 1'b1;
                        m_nop   = 1'b0;
                    end else if (!(m_valid && !s.ready)) begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        stim_q.delete();
        repeat (3) tick();

        // Reset values while held in reset
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_instr", instr_o, c_nop);
        chk("rst_pc_o", pc_o, 32'd0);
        chk("rst_pc_plus4", pc_plus4_o, 32'd4);
        chk("rst_cnt", fetch_cnt_o, 32'd0);
        chk("rst_imem_a", imem_a, 32'd0);

        // Release reset and start the stream
        tick();
        rst_n   = 1'b1;
        m_valid = 1'b0; m_pc = 32'd0; m_cnt = 32'd0; m_mis = 1'b0; m_nop = 1'b1;
        mon_on  = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'd0);

        tick(); chk("s0_pc", pc_o, 32'h0); chk("s0_instr", instr_o, 32'hA000_0000);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); chk("s1_pc", pc_o, 32'h4); chk("s1_instr", instr_o, 32'hA000_0001);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); chk("s2_pc", pc_o, 32'h8); chk("s2_instr", instr_o, 32'hA000_0002);

        // Stall for three cycles at pc 0x8
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            tick();
            chk("stall_instr", instr_o, 32'hA000_0002);
            chk("stall_imem_a", imem_a, 32'hC);
            chk("stall_cnt", fetch_cnt_o, 32'd2);
        end
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); chk("post_stall_pc", pc_o, 32'hC); chk("post_stall_instr", instr_o, 32'hA000_0003);
        chk("cnt_three", fetch_cnt_o, 32'd3);

        // Redirect while stalled
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h40);
        tick(); chk("redir_valid", {31'd0, valid_o}, 32'd0); chk("redir_nop", instr_o, c_nop);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); chk("redir_pc", pc_o, 32'h40); chk("redir_instr", instr_o, 32'hA000_0010);

        // Misaligned redirect
        drive(1'b1, 1'b1, 1'b1, 32'h46);
        tick(); chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); chk("mis_clear", {31'd0, misalign_o}, 32'd0); chk("mis_pc", pc_o, 32'h44);

        // Wrap at the top of the address space
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); chk("wrap_pc", pc_o, 32'hFFFF_FFFC); chk("wrap_plus4", pc_plus4_o, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick(); chk("wrap_next_pc", pc_o, 32'h0);

        // Enable off: drain and hold
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        tick(); chk("drain_valid", {31'd0, valid_o}, 32'd0); chk("drain_imem_a", imem_a, 32'h4);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        tick(); chk("idle_imem_a", imem_a, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic en, rdy, rd;
            en  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       tgt = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
                1:       tgt = $urandom;
                2:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: tgt = 32'($urandom_range(0, 1023));
            endcase
            drive(en, rdy, rd, tgt);
            tick();
        end

        // Hold a stalled instruction, then async reset between edges
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        mon_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_o}, 32'd0);
        chk("arst_instr", instr_o, c_nop);
        chk("arst_pc_o", pc_o, 32'd0);
        chk("arst_pc_plus4", pc_plus4_o, 32'd4);
        chk("arst_misalign", {31'd0, misalign_o}, 32'd0);
        chk("arst_cnt", fetch_cnt_o, 32'd0);
        chk("arst_imem_a", imem_a, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
